mac_accumulator: RTL and testbench
==================================

// Module: mac_accumulator
// PURPOSE
//  Sequential multiply-accumulate stage wrapped around the unsigned WIDTH-bit combinational
//  array multiplier (module `multiplier`). It takes operand pairs over a valid/ready
//  stream, pipelines them through the multiplier and accumulates the products into a
//  dot-product sum. On the term flagged last, it emits {sum, term count, overflow} over a
//  second valid/ready stream.
// PARAMETERS
//  WIDTH      8            operand width (unsigned); product is 2*WIDTH bits
//  ACC_WIDTH  2*WIDTH+4    accumulator/result width (must be >= 2*WIDTH)
//  CNT_WIDTH  8            term-counter width
// PORTS
//  clk        in   1          single clock; all state updates on rising edge
//  rst_n      in   1          reset: asynchronous, active-low
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          stage accepts a pair this cycle
//  in_a       in   WIDTH      multiplicand (unsigned)
//  in_b       in   WIDTH      multiplier (unsigned)
//  in_last    in   1          pair is final term of current group
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts result
//  out_sum    out  ACC_WIDTH  sum of a*b over the group, modulo 2^ACC_WIDTH
//  out_count  out  CNT_WIDTH  terms in group, saturates at 2^CNT_WIDTH-1
//  out_ovf    out  1          sticky: accumulator carried out at least once in group
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=ACCUM, all pipeline valids=0, acc=0, count=0, ovf=0.
//    While in reset: out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=0.
//    After release: in_ready=1 and no partial group survives.
//  - Handshake: a transfer occurs when valid&&ready at a rising edge. in_ready is a function
//    of state only (no combinational path from in_valid). out_* are registers and hold
//    stable while out_valid=1 && out_ready=0.
//  - Pipeline:
//      S1 register {a,b,last,v1}, loaded on input transfer.
//      Multiplier fed from S1.
//      S2 register {prod[2*WIDTH-1:0], last2, v2}.
//      Accumulate from S2.
//  - FSM:
//      ACCUM: in_ready=1. A transfer with in_last=1 moves the FSM to FLUSH.
//      FLUSH: in_ready=0. Waits for the last term to reach S2.
//      DONE:  in_ready=0, out_valid=1. out_valid&&out_ready moves the FSM to ACCUM.
//  - Accumulate: when v2=1, {carry,acc} = acc + zero-extended prod; count=sat(count+1);
//    ovf |= carry.
//  - When v2&&last2:
//      out_sum   <= acc+prod (wrapped), out_count <= sat(count+1), out_ovf <= ovf|carry.
//      acc, count, ovf are cleared.
//      State moves FLUSH->DONE.
//  - Latency: if the in_last transfer is in cycle T, out_valid=1 from cycle T+3.
//    Min group turnaround: 1 cycle after out handshake, in_ready=1.
//  - Throughput: one pair per cycle in ACCUM; no bubbles required.
//  - Single-term group (first pair has in_last=1) is legal and yields count=1.
//  - in_a/in_b/in_last ignored when no transfer; in_valid may drop between terms freely.
//  - Reset mid-group or in DONE: pending result discarded, no out_valid pulse.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles, release.
//    -> in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
//  2 Basic group: pairs (3,4),(5,6),(7,8 last) on consecutive cycles, out_ready=1.
//    -> out_sum=98, out_count=3, out_ovf=0, out_valid 3 cycles after last transfer.
//  3 Max single term: (255,255,last).
//    -> out_sum=65025, out_count=1, out_ovf=0.
//  4 Overflow: ACC_WIDTH=20, 17 terms of (255,255), last on 17th.
//    -> out_sum=56849 (1105425 mod 2^20), out_count=17, out_ovf=1.
//  5 Backpressure: group (2,2),(3,3 last), out_ready=0 for 5 cycles after out_valid.
//    -> out_sum=13 held stable, in_ready=0 throughout. After handshake, next group
//       (1,1 last) -> out_sum=1, out_count=1, out_ovf=0.
//  6 Reset mid-group: accept (9,9),(9,9), pulse rst_n=0, then (2,3 last).
//    -> out_sum=6, out_count=1. No out_valid before the new group completes.

Source files
------------

// File: rtl/mac_accumulator_if.sv
// Operand and result streams of the multiply-accumulate stage, both valid/ready.
// The slave modport is the accumulator's view; the master modport is the producer/consumer's view.
interface mac_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/mac_accumulator.sv
// Dot-product MAC: operand pairs go S1 -> array multiplier -> S2 -> accumulator.
// The group total is emitted on the term flagged last.
module multiplier #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_p
);
  // Shift-and-add rows; each set bit of i_b contributes i_a shifted to its weight.
  always_comb begin
    o_p = '0;
    for (int i = 0; i < WIDTH; i++)
      if (i_b[i]) o_p = o_p + ({{WIDTH{1'b0}}, i_a} << i);
  end
endmodule

module mac_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4,
  parameter int CNT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mac_accumulator_if.slave  bus
);
  typedef enum logic [1:0] {ACCUM, FLUSH, DONE} state_t;

  state_t               r_state, w_next;
  logic                 w_in_ready, w_out_valid, w_in_xfer;

  logic [WIDTH-1:0]     r_a, r_b;
  logic                 r_last1, r_v1;
  logic [2*WIDTH-1:0]   w_prod, r_prod;
  logic                 r_last2, r_v2;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_count, w_cnt_inc;
  logic                 r_ovf;
  logic [ACC_WIDTH:0]   w_sum;

  logic [ACC_WIDTH-1:0] r_out_sum;
  logic [CNT_WIDTH-1:0] r_out_count;
  logic                 r_out_ovf;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCUM:   if (w_in_xfer && bus.in_last) w_next = FLUSH;
      FLUSH:   if (r_v2 && r_last2)          w_next = DONE;
      DONE:    if (bus.out_ready)            w_next = ACCUM;
      default: w_next = ACCUM;
    endcase
  end

  // FSM outputs; in_ready is held low while reset is asserted
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ACCUM:   w_in_ready  = rst_n;
      DONE:    w_out_valid = 1'b1;
      default: ;
    endcase
  end

  assign w_in_xfer = bus.in_valid && w_in_ready;

  multiplier #(.WIDTH(WIDTH)) u_mul (.i_a(r_a), .i_b(r_b), .o_p(w_prod));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_last1 <= 1'b0;
      r_v1    <= 1'b0;
      r_prod  <= '0;
      r_last2 <= 1'b0;
      r_v2    <= 1'b0;
    end else begin
      r_v1 <= w_in_xfer;
      if (w_in_xfer) begin
        r_a     <= bus.in_a;
        r_b     <= bus.in_b;
        r_last1 <= bus.in_last;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_prod  <= w_prod;
        r_last2 <= r_last1;
      end
    end
  end

  assign w_sum     = {1'b0, r_acc} + {{(ACC_WIDTH+1-2*WIDTH){1'b0}}, r_prod};
  assign w_cnt_inc = (&r_count) ? r_count : r_count + 1'b1;

  // The last term bypasses the accumulator straight into the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (r_v2) begin
      if (r_last2) begin
        r_out_sum   <= w_sum[ACC_WIDTH-1:0];
        r_out_count <= w_cnt_inc;
        r_out_ovf   <= r_ovf | w_sum[ACC_WIDTH];
        r_acc       <= '0;
        r_count     <= '0;
        r_ovf       <= 1'b0;
      end else begin
        r_acc   <= w_sum[ACC_WIDTH-1:0];
        r_count <= w_cnt_inc;
        r_ovf   <= r_ovf | w_sum[ACC_WIDTH];
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: reset, basic group, max term, overflow,
// output backpressure and reset in the middle of a group.
module tb_mac_accumulator;
  localparam int WIDTH = 8, ACC_WIDTH = 20, CNT_WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   lat;

  always #5 clk = ~clk;

  mac_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  mac_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one pair at the negedge; it transfers on the following posedge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    @(posedge clk);
  endtask

  // Count cycles from the last transfer until out_valid, bounded.
  task automatic wait_out(output int l);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = 8'hxx;
    bus.in_b     = 8'hxx;
    l = 1;
    while (!bus.out_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid_low", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);

    // Basic group: 12+30+56
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b0);
    send(8'd7, 8'd8, 1'b1);
    wait_out(lat);
    chk("basic_latency", 32'(lat), 32'd3);
    chk("basic_valid", 32'(bus.out_valid), 32'd1);
    chk("basic_in_ready_done", 32'(bus.in_ready), 32'd0);
    chk("basic_sum", 32'(bus.out_sum), 32'd98);
    chk("basic_count", 32'(bus.out_count), 32'd3);
    chk("basic_ovf", 32'(bus.out_ovf), 32'd0);
    @(negedge clk);
    chk("basic_turnaround_ready", 32'(bus.in_ready), 32'd1);
    chk("basic_valid_cleared", 32'(bus.out_valid), 32'd0);

    // Max single term
    send(8'd255, 8'd255, 1'b1);
    wait_out(lat);
    chk("max_latency", 32'(lat), 32'd3);
    chk("max_sum", 32'(bus.out_sum), 32'd65025);
    chk("max_count", 32'(bus.out_count), 32'd1);
    chk("max_ovf", 32'(bus.out_ovf), 32'd0);
    @(negedge clk);

    // Overflow: 17*65025 = 1105425, mod 2^20 = 56849
    for (int i = 0; i < 17; i++) send(8'd255, 8'd255, (i == 16));
    wait_out(lat);
    chk("ovf_latency", 32'(lat), 32'd3);
    chk("ovf_sum", 32'(bus.out_sum), 32'd56849);
    chk("ovf_count", 32'(bus.out_count), 32'd17);
    chk("ovf_flag", 32'(bus.out_ovf), 32'd1);
    @(negedge clk);

    // Backpressure on the result
    bus.out_ready = 1'b0;
    send(8'd2, 8'd2, 1'b0);
    send(8'd3, 8'd3, 1'b1);
    wait_out(lat);
    chk("bp_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
      chk("bp_sum_held", 32'(bus.out_sum), 32'd13);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_released_ready", 32'(bus.in_ready), 32'd1);
    send(8'd1, 8'd1, 1'b1);
    wait_out(lat);
    chk("bp_next_sum", 32'(bus.out_sum), 32'd1);
    chk("bp_next_count", 32'(bus.out_count), 32'd1);
    chk("bp_next_ovf", 32'(bus.out_ovf), 32'd0);
    @(negedge clk);

    // Reset mid-group discards partial sum
    send(8'd9, 8'd9, 1'b0);
    send(8'd9, 8'd9, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_sum_clear", 32'(bus.out_sum), 32'd0);
    rst_n = 1'b1;
    send(8'd2, 8'd3, 1'b1);
    wait_out(lat);
    chk("midrst_latency", 32'(lat), 32'd3);
    chk("midrst_sum", 32'(bus.out_sum), 32'd6);
    chk("midrst_count", 32'(bus.out_count), 32'd1);
    chk("midrst_ovf", 32'(bus.out_ovf), 32'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
